// File: rtl/pu_or1k_wb_ram.sv
// rtl/pu_or1k_wb_ram.sv - Wishbone B3 slave RAM with classic cycles, registered-feedback bursts and byte lanes
// Out-of-range requests return err instead of ack; bursts may be linear or wrap-4/8/16.
module pu_or1k_wb_ram #(
  parameter int unsigned MEM_SIZE = 32'h02000000,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int unsigned IW    = $clog2(MEM_SIZE);
  localparam int unsigned WORDS = MEM_SIZE / 4;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [DW-1:0] mem [0:WORDS-1];

  state_t        r_state;
  logic [AW-1:0] r_next;
  logic          r_ack;
  logic          r_err;
  logic [DW-1:0] r_dat;

  logic          w_req;
  logic [IW-3:0] w_idx;
  logic          w_oor;
  logic          w_cti_inc;
  logic          w_cti_end;
  logic          w_start;
  logic          w_beat;
  logic          w_acc;
  logic          w_wr;

  // Wrap bursts only advance the low address bits covered by the mask; upper bits stay put.
  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] m;
    logic [AW-1:0] s;
    s = a + AW'(4);
    case (bte)
      2'b01:   m = AW'(15);
      2'b10:   m = AW'(31);
      2'b11:   m = AW'(63);
      default: m = '1;
    endcase
    return (a & ~m) | (s & m);
  endfunction

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_idx     = wb_adr_i[IW-1:2];
  assign w_oor     = |wb_adr_i[AW-1:IW];
  assign w_cti_inc = (wb_cti_i == 3'b010);
  assign w_cti_end = (wb_cti_i == 3'b111);
  assign w_start   = (r_state == S_IDLE) & w_req & ~r_ack & ~r_err;
  assign w_beat    = (r_state == S_BURST) & w_req & (w_cti_inc | w_cti_end) & (wb_adr_i == r_next);
  assign w_acc     = (w_start | w_beat) & ~w_oor;
  // A reset landing on the clock edge must not commit a partial beat.
  assign w_wr      = w_acc & wb_we_i & ~wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_next  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (!wb_cyc_i) begin
        r_state <= S_IDLE;
      end else if (w_start | w_beat) begin
        if (w_oor) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_ack  <= 1'b1;
          r_next <= f_inc(wb_adr_i, wb_bte_i);
          if (!wb_we_i) r_dat <= mem[w_idx];
          if (w_start) r_state <= w_cti_inc ? S_BURST : S_IDLE;
          else if (w_cti_end) r_state <= S_IDLE;
        end
      end else if (r_state == S_BURST) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;

endmodule

// File: doc/pu_or1k_wb_ram.md
Name: pu_or1k_wb_ram

Overview:
- Wishbone B3 slave RAM on the data/instruction bus of the pu_or1k_wb processing unit, directly downstream of the CPU bus masters.
- Supports classic single cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16).
- Supports byte-lane writes and bus-error signalling for out-of-range addresses.
- The internal word array is named mem, so the bench can preload it hierarchically (ELF load, clear_ram).

Parameters:
- MEM_SIZE, 32'h02000000, memory size in bytes; must be a power of two and ≥ 64.
- AW, 32, Wishbone address width.
- DW, 32, data width; fixed at 32 in this revision.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- wb_adr_i  in  AW  byte address; bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane enables; bit 3 = dat[31:24]
- wb_we_i   in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out 32  read data, registered
- wb_ack_o  out 1  acknowledge, registered
- wb_err_o  out 1  error, registered
- wb_rty_o  out 1  tied 0

Behaviour:
- Reset (async assert, sync release): ack_o=0, err_o=0, dat_o=0, FSM=IDLE. mem contents are not altered.
- Request: req = cyc_i & stb_i. Word index = adr_i[log2(MEM_SIZE)-1:2]. Out of range (oor) = adr_i ≥ MEM_SIZE.
- FSM state IDLE:
  - If req & !ack_o & !err_o: next cycle asserts ack_o (or err_o if oor) for one cycle. Latency is 1 cycle.
  - Read: dat_o = mem[index] in the same edge as ack.
  - Write: each byte whose sel_i bit is set is written at that edge. On err there is no write and dat_o is unchanged.
  - If cti_i==010 and not oor: go to BURST, next_adr = inc(adr_i).
- FSM state BURST:
  - Each cycle with req & cti_i∈{010,111} & adr_i==next_adr: ack_o stays 1 and the beat completes (read data prefetched from next_adr, write committed).
  - next_adr = inc(adr_i).
  - cti_i==111 acks that beat, then goes to IDLE; ack_o drops the following cycle.
- Burst abort: stb_i low, cyc_i low, adr_i ≠ next_adr, or cti_i==000 while in BURST. ack_o=0 next cycle, go to IDLE, no write. The master re-issues, and the request restarts as a fresh IDLE access.
- inc(a): word increment per bte_i.
  - linear: a+4.
  - wrap N: low log2(N)+2 address bits increment modulo N*4; upper bits are kept.
- Burst crossing MEM_SIZE (linear): the beat whose address is oor gets err_o instead of ack_o, and the FSM goes to IDLE.
- ack_o and err_o are never both 1.
- dat_o holds its last value when not acking.
- wb_cyc_i low forces IDLE at the next edge regardless of state.
- Reset mid-burst: outputs clear immediately. A write acked before reset is retained; no partial beat is written.

Test Plan:
- Classic write adr=0x100, dat=0xDEADBEEF, sel=1111, then classic read 0x100 → ack 1 cycle after each strobe, read data 0xDEADBEEF, ack low in between.
- Byte write sel=0010, dat=0x0000AB00 to 0x100, then read → 0xDEADABEF.
- Wrap-4 read burst starting at 0x208 (mem preloaded word k = k) → acks on 4 consecutive cycles, addresses 0x208, 0x20C, 0x200, 0x204, data 0x82, 0x83, 0x80, 0x81, final beat cti=111, ack low next cycle.
- Linear write burst of 8 beats at 0x1000 with stb dropped for 2 cycles after beat 3 → ack low during the gap, burst restarts at 0x100C, all 8 words correct on read-back, no spurious writes.
- Classic read at MEM_SIZE and a linear burst from MEM_SIZE-8 → err_o (not ack) on the oor beat, memory at 0 is unmodified.
- Assert wb_rst_i mid-burst after beat 2 → ack_o=0 in the same cycle, beats 0 and 1 retained, beat 2 not written, next classic access is acked normally.
